// File: rtl/foo_stream_checker.sv
// foo_stream_checker
//
// In-order stream checker for the foo datapath. Every accepted input beat is
// queued as an expected value. Every output beat is compared against the
// queue head, which is then popped. The block keeps saturating event
// counters, a sticky record of the first error and, optionally, a
// per-head latency timeout.
//
// Optional feature macro: FOO_STREAM_CHK_LATENCY_EN
//   defined   -> an age counter watches the queue head and raises a timeout
//                (err_code 4) when the head has waited TIMEOUT cycles.
//   undefined -> no age logic is built and err_code 4 never occurs.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset (queue storage is not reset)
//   clear           synchronous clear of queue, counters and error state;
//                   beats in the same cycle are ignored
//   test_in_valid   DUT input beat valid
//   test_in         DUT input data
//   test_out_valid  DUT output beat valid
//   test_out        DUT output data
//   pending         number of queued entries
//   in_count        accepted input beats (saturating)
//   out_count       output beats (saturating)
//   match_count     output beats equal to the expected value (saturating)
//   mismatch_count  output beats differing from the expected value (saturating)
//   error           sticky, set on the first error
//   err_code        first-error cause: 0 none, 1 mismatch, 2 underflow,
//                   3 overflow, 4 timeout
//   err_exp         expected data of the first error if it was a mismatch
//   err_got         received data of the first error if it was a mismatch

module foo_stream_checker #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              test_in_valid,
  input  logic [DATA_W-1:0] test_in,
  input  logic              test_out_valid,
  input  logic [DATA_W-1:0] test_out,
  output logic [PTR_W:0]    pending,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_MISMATCH  = 3'd1;
  localparam logic [2:0] CODE_UNDERFLOW = 3'd2;
  localparam logic [2:0] CODE_OVERFLOW  = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

  typedef enum logic {ST_OK, ST_ERR} state_t;

  state_t            state;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head;

  logic empty, full;
  logic push, pop;
  logic overflow_ev, underflow_ev, match_ev, mismatch_ev, timeout_ev;
  logic       err_raise;
  logic [2:0] raise_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // The compare sees the head as it stood before any same-cycle push. A pop
  // at full frees a slot, so a simultaneous push is accepted.
  assign pop          = !clear && test_out_valid && !empty;
  assign underflow_ev = !clear && test_out_valid && empty;
  assign push         = !clear && test_in_valid && (!full || pop);
  assign overflow_ev  = !clear && test_in_valid && full && !pop;
  assign match_ev     = pop && (head == test_out);
  assign mismatch_ev  = pop && (head != test_out);

  assign pending = wr_ptr - rd_ptr;

`ifdef FOO_STREAM_CHK_LATENCY_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  logic [AGE_W-1:0] age;

  // The event fires on the edge where age reaches TIMEOUT; the counter then
  // freezes there, so it fires only once per head entry.
  assign timeout_ev = !clear && !empty && !pop && (age == AGE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age <= '0;
    end else if (clear || pop || (push && empty)) begin
      age <= '0;
    end else if (!empty && (age != AGE_W'(TIMEOUT))) begin
      age <= age + AGE_W'(1);
    end
  end
`else
  assign timeout_ev = 1'b0;
`endif

  // Highest-priority cause when several errors coincide.
  always_comb begin
    err_raise  = 1'b1;
    raise_code = CODE_NONE;
    if (overflow_ev)       raise_code = CODE_OVERFLOW;
    else if (underflow_ev) raise_code = CODE_UNDERFLOW;
    else if (mismatch_ev)  raise_code = CODE_MISMATCH;
    else if (timeout_ev)   raise_code = CODE_TIMEOUT;
    else                   err_raise  = 1'b0;
  end

  // Queue storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= test_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      in_count       <= '0;
      out_count      <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      state          <= ST_OK;
      error          <= 1'b0;
      err_code       <= CODE_NONE;
      err_exp        <= '0;
      err_got        <= '0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      in_count       <= '0;
      out_count      <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      state          <= ST_OK;
      error          <= 1'b0;
      err_code       <= CODE_NONE;
      err_exp        <= '0;
      err_got        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      in_count       <= sat_inc(in_count, push);
      out_count      <= sat_inc(out_count, test_out_valid);
      match_count    <= sat_inc(match_count, match_ev);
      mismatch_count <= sat_inc(mismatch_count, mismatch_ev);

      case (state)
        ST_OK: begin
          if (err_raise) begin
            state    <= ST_ERR;
            error    <= 1'b1;
            err_code <= raise_code;
            if (raise_code == CODE_MISMATCH) begin
              err_exp <= head;
              err_got <= test_out;
            end
          end
        end
        default: begin
          // First error stays latched until clear or reset.
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/foo_stream_checker.md
# foo_stream_checker

Synthesisable, parametrised in-order stream checker for the foo datapath. It samples the DUT's input and output valid/data streams, queues input samples as expected values, and compares each output beat in order against the queue head. It keeps saturating event counters, a sticky first-error record and, optionally, a per-transaction latency timeout. It sits beside the DUT in the bench and can also be instantiated for on-chip self-check.

## Interface
- DATA_W, default 8: width of test_in / test_out.
- DEPTH, default 16: expected-value queue depth, power of two, ≥2.
- CNT_W, default 16: width of each event counter.
- TIMEOUT, default 64: maximum cycles a queue-head entry may wait; used only with the latency check compiled in.
- PTR_W, derived $clog2(DEPTH): queue pointer width.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- clear  input  1  synchronous clear of queue, counters and error state.
- test_in_valid  input  1  DUT input beat valid.
- test_in  input  DATA_W  DUT input data.
- test_out_valid  input  1  DUT output beat valid.
- test_out  input  DATA_W  DUT output data.
- pending  output  PTR_W+1  number of entries currently queued.
- in_count, out_count, match_count, mismatch_count  output  CNT_W each  saturating event counters.
- error  output  1  sticky; set on the first error.
- err_code  output  3  first-error cause: 0 none, 1 mismatch, 2 underflow, 3 overflow, 4 timeout.
- err_exp, err_got  output  DATA_W each  expected and received data of the first mismatch.

## Operation
- Queue: circular buffer with read and write pointers of PTR_W+1 bits. Full when the pointers' low bits are equal and the MSBs differ. Empty when the pointers are equal.
- Input beat: if not full, push test_in and increment in_count. If full, drop the beat, do not count it, and raise overflow (code 3).
- Output beat: increment out_count.
  - If the queue is non-empty, pop the head and compare it to test_out. On equality, increment match_count. On inequality, increment mismatch_count and raise mismatch (code 1).
  - If the queue is empty at the start of the cycle, raise underflow (code 2) and pop nothing.
- Simultaneous input and output beats:
  - The compare uses the head as it stood before the push.
  - With a non-empty queue, push and pop both occur and pending is unchanged.
  - With an empty queue, the push occurs and the output beat is an underflow.
  - With a full queue, the pop frees a slot, so the push succeeds and there is no overflow.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Error state machine, two states:
  - OK → ERR on the first raised error. err_code is latched, and err_exp/err_got are latched for a mismatch; all three stay zero otherwise.
  - ERR holds until clear or reset. Later errors still update the counters but do not change err_code or err_exp/err_got.
  - If several errors occur in one cycle, priority is overflow > underflow > mismatch > timeout.
- clear: has priority over beats presented in the same cycle; those beats are ignored. It empties the queue, zeroes all counters and returns the state machine to OK.

## Timing
- All outputs are registered and take effect on the rising edge after the sampled beat (one-cycle latency). This matches the bench's clocking (input sampled #1step before the edge).
- Reset: when reset_n falls, all outputs go to 0 immediately, both pointers go to 0 and the state goes to OK. Queue storage is not reset.
- Reset asserted mid-stream discards all queued entries. The first beats after reset_n rises are treated as fresh; an output beat then counts as underflow.
- pending equals the write pointer minus the read pointer, modulo 2^(PTR_W+1). It is valid on the same edge as the counters.

## Configuration
- FOO_STREAM_CHK_LATENCY_EN defined:
  - An age counter tracks how many cycles the current head has waited. It resets to 0 on every pop, on a push into an empty queue, and on clear.
  - When the age reaches TIMEOUT, timeout (code 4) is raised once per head entry and the age counter freezes. The entry remains queued and is still compared when its output arrives.
- FOO_STREAM_CHK_LATENCY_EN undefined: no age counter and no TIMEOUT logic are built, and code 4 is never produced.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 and receive outputs 0x11, 0x22, 0x33 three cycles later → in_count = out_count = match_count = 3, error = 0, pending = 0.
- Push 0xA5, then receive output 0x5A → mismatch_count = 1, error = 1, err_code = 1, err_exp = 0xA5, err_got = 0x5A. A following correct beat still increments match_count and leaves err_code at 1.
- Output beat with the queue empty, presented in the same cycle as a push of 0x01 → err_code = 2, pending = 1, match_count = 0.
- DEPTH = 16: push 17 beats with no outputs → pending = 16, in_count = 16, err_code = 3. Then push and pop in the same cycle at full → no new error, pending stays 16.
- With FOO_STREAM_CHK_LATENCY_EN and TIMEOUT = 64: push one beat and hold outputs off for 70 cycles → err_code = 4 on the 64th cycle of waiting. The late correct output then increments match_count.
- Assert reset_n low for 2 cycles with pending = 5, then release and send an output beat → pending = 0 during reset, err_code = 2 after the beat.
